// File: rtl/nn_cfg_pkg.sv
// -----------------------------------------------------------------------------
// nn_cfg_pkg
// Shared configuration for the small feed-forward network and its serial
// weight-load path.
//   - tx_state_t   : state encoding of the weight stream transmitter
//   - N_IN/N_HID/N_OUT : layer sizes (inputs, hidden neurons, output neurons)
//   - W_WIDTH/W_ADDR   : weight word width and weight address width
//   - NUM_WEIGHTS      : total weights in one load (hidden + output layers)
//   - NEURON_BASE / neuron_base() : first weight address of each neuron
// -----------------------------------------------------------------------------
package nn_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } tx_state_t;

   localparam int N_IN    = 10;
   localparam int N_HID   = 5;
   localparam int N_OUT   = 3;
   localparam int W_WIDTH = 10;
   localparam int W_ADDR  = 7;

   // Hidden neurons carry N_IN weights each, output neurons N_HID each.
   localparam int NUM_WEIGHTS = N_IN * N_HID + N_HID * N_OUT;

   localparam int N_NEURONS = N_HID + N_OUT;

   // Hidden neurons 0..4 start at 0,10,20,30,40; output neurons at 50,55,60.
   localparam logic [W_ADDR-1:0] NEURON_BASE [0:N_NEURONS-1] = '{
      7'd0, 7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd55, 7'd60
   };

   // Arithmetic form of NEURON_BASE; neuron n counts hidden neurons first.
   function automatic logic [W_ADDR-1:0] neuron_base(input int unsigned n);
      int unsigned base;
      if (n < N_HID)
         base = n * N_IN;
      else
         base = N_IN * N_HID + (n - N_HID) * N_HID;
      return W_ADDR'(base);
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
// Parallel-in / serial-out shift register, MSB first. A load overrides a shift;
// shifting moves the word left with zero fill so the register drains to zero
// after WIDTH shifts, which keeps the serial tap low between words.
//   clk   in          clock, rising edge
//   rst   in          asynchronous reset, active-high (clears the register)
//   load  in          capture din on the next edge
//   shift in          shift left by one on the next edge (ignored when load=1)
//   din   in  WIDTH   parallel word, passed bit-exact (sign lives in the MSB)
//   msb   out         serial tap, bit WIDTH-1 of the register
// -----------------------------------------------------------------------------
module piso_shreg #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         shreg <= '0;
      else if (load)
         shreg <= din;
      else if (shift)
         shreg <= {shreg[WIDTH-2:0], 1'b0};
   end

   assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/weight_stream_tx.sv
// -----------------------------------------------------------------------------
// weight_stream_tx
// Transmit side of the serial weight-load interface. Reads NUM_WEIGHTS words
// from a synchronous ROM in address order and shifts each one out MSB first
// with WE high, tagging every bit with its weight address and bit index.
// Each weight costs WIDTH+2 cycles: one to present the address, one for the
// ROM to return data, then WIDTH shift cycles.
//   Clock   in           system clock, rising edge
//   Rst     in           asynchronous reset, active-high
//   Start   in           load request, looked at only while idle
//   Abort   in           synchronous abort, honoured while a load is running
//   RomAddr out ADDR_W   ROM read address
//   RomData in  WIDTH    ROM read data, valid the cycle after RomAddr
//   Out     out          serial weight bit
//   WE      out          bit valid / RAM write enable
//   WAddr   out ADDR_W   address of the weight currently on Out
//   WBit    out 4        bit position on Out, WIDTH-1 down to 0
//   Busy    out          load in progress
//   Done    out          one-cycle pulse after the last bit of a full load
// -----------------------------------------------------------------------------
module weight_stream_tx
   import nn_cfg_pkg::*;
#(
   parameter int NUM_WEIGHTS = nn_cfg_pkg::NUM_WEIGHTS,
   parameter int WIDTH       = nn_cfg_pkg::W_WIDTH,
   parameter int ADDR_W      = nn_cfg_pkg::W_ADDR
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic              Abort,
   output logic [ADDR_W-1:0] RomAddr,
   input  logic [WIDTH-1:0]  RomData,
   output logic              Out,
   output logic              WE,
   output logic [ADDR_W-1:0] WAddr,
   output logic [3:0]        WBit,
   output logic              Busy,
   output logic              Done
);

   // Parameter sanity: the index must be able to reach the last weight, and
   // the bit index has to fit the 4-bit WBit port.
   if (NUM_WEIGHTS < 1 || NUM_WEIGHTS > (1 << ADDR_W)) begin : g_bad_num_weights
      $error("weight_stream_tx: NUM_WEIGHTS must be in 1..2**ADDR_W");
   end
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("weight_stream_tx: WIDTH must be in 2..16");
   end

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);
   localparam logic [3:0]        TOP_BIT  = 4'(WIDTH - 1);

   tx_state_t         state;
   logic [ADDR_W-1:0] index;
   logic [3:0]        bitcnt;

   logic              abort_now;
   logic              last_bit;
   logic              sh_load;
   logic              sh_shift;
   logic [WIDTH-1:0]  sh_din;

   assign abort_now = Abort && (state == FETCH || state == WAIT || state == SHIFT);
   assign last_bit  = (bitcnt == 4'd0);

   // The shift register is the Out flop. An abort loads zero so a half-sent
   // word cannot leak onto Out after WE drops; otherwise the register drains
   // to zero by itself at the end of each word.
   assign sh_load  = abort_now || (state == WAIT);
   assign sh_shift = (state == SHIFT) && !abort_now;
   assign sh_din   = abort_now ? '0 : RomData;

   piso_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .clk   (Clock),
      .rst   (Rst),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (sh_din),
      .msb   (Out)
   );

   // WBit is the bit counter itself; it rests at 0 outside the shift window
   // because the last shift leaves it at 0 and an abort clears it.
   assign WBit = bitcnt;

   // Control FSM. Outputs are assigned on the edge that enters the state in
   // which they must be visible, so every output is a flop.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state   <= IDLE;
         index   <= '0;
         bitcnt  <= '0;
         RomAddr <= '0;
         WAddr   <= '0;
         WE      <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (abort_now) begin
            // Abort beats the end-of-word transition; WAddr keeps its value.
            state   <= IDLE;
            index   <= '0;
            bitcnt  <= '0;
            RomAddr <= '0;
            WE      <= 1'b0;
            Busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (Start) begin
                     state   <= FETCH;
                     index   <= '0;
                     RomAddr <= '0;
                     Busy    <= 1'b1;
                  end
               end
               FETCH: begin
                  // RomAddr already holds index; the ROM answers next cycle.
                  state <= WAIT;
               end
               WAIT: begin
                  state  <= SHIFT;
                  bitcnt <= TOP_BIT;
                  WAddr  <= index;
                  WE     <= 1'b1;
               end
               SHIFT: begin
                  if (last_bit) begin
                     WE <= 1'b0;
                     if (index == LAST_IDX) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                     end else begin
                        state   <= FETCH;
                        index   <= index + 1'b1;
                        RomAddr <= index + 1'b1;
                     end
                  end else begin
                     bitcnt <= bitcnt - 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  WE    <= 1'b0;
                  Busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_weight_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_weight_stream_tx
// Directed bench for weight_stream_tx with a behavioural synchronous ROM.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_weight_stream_tx;

   localparam int NW = 65;
   localparam int W  = 10;
   localparam int AW = 7;

   logic          Clock = 1'b0;
   logic          Rst   = 1'b1;
   logic          Start = 1'b0;
   logic          Abort = 1'b0;
   logic [AW-1:0] RomAddr;
   logic [W-1:0]  RomData;
   logic          Out;
   logic          WE;
   logic [AW-1:0] WAddr;
   logic [3:0]    WBit;
   logic          Busy;
   logic          Done;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] rom [0:(1<<AW)-1];

   weight_stream_tx #(
      .NUM_WEIGHTS (NW),
      .WIDTH       (W),
      .ADDR_W      (AW)
   ) dut (
      .Clock   (Clock),
      .Rst     (Rst),
      .Start   (Start),
      .Abort   (Abort),
      .RomAddr (RomAddr),
      .RomData (RomData),
      .Out     (Out),
      .WE      (WE),
      .WAddr   (WAddr),
      .WBit    (WBit),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   // Synchronous ROM: data for an address appears one cycle later.
   always @(posedge Clock) RomData <= rom[RomAddr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [W-1:0] single_w;
   logic [W-1:0] word;
   int           nwe;
   int           slot;
   int           widx;
   int           bpos;
   int           done_k;
   bit           exp_we;
   bit           found;

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom[i] = '0;

      // ---------------- reset, then idle with Start low
      tick();
      tick();
      check("rst_we",      WE,      0);
      check("rst_busy",    Busy,    0);
      check("rst_done",    Done,    0);
      check("rst_out",     Out,     0);
      check("rst_romaddr", RomAddr, 0);
      check("rst_waddr",   WAddr,   0);
      check("rst_wbit",    WBit,    0);
      Rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("idle_we",      WE,      0);
         check("idle_busy",    Busy,    0);
         check("idle_done",    Done,    0);
         check("idle_out",     Out,     0);
         check("idle_romaddr", RomAddr, 0);
      end

      // ---------------- single weight, MSB-first bit order (-509)
      single_w = 10'b1000000011;
      rom[0] = single_w;
      rom[1] = 10'h155;
      Start = 1'b1;
      tick();                       // Start edge; now in cycle 1
      Start = 1'b0;
      check("sw_c1_busy",    Busy,    1);
      check("sw_c1_we",      WE,      0);
      check("sw_c1_romaddr", RomAddr, 0);
      tick();
      check("sw_c2_we",      WE,      0);
      check("sw_c2_out",     Out,     0);
      for (int b = 0; b < W; b++) begin
         tick();
         check("sw_we",    WE,    1);
         check("sw_out",   Out,   single_w[W-1-b]);
         check("sw_wbit",  WBit,  W-1-b);
         check("sw_waddr", WAddr, 0);
      end
      tick();                       // fetch of weight 1
      check("sw_gap_we",      WE,      0);
      check("sw_gap_out",     Out,     0);
      check("sw_gap_wbit",    WBit,    0);
      check("sw_gap_waddr",   WAddr,   0);
      check("sw_gap_romaddr", RomAddr, 1);
      Abort = 1'b1;                 // abort during FETCH
      tick();
      Abort = 1'b0;
      check("sw_abort_busy", Busy, 0);
      check("sw_abort_we",   WE,   0);

      // ---------------- Abort ignored in IDLE; Start wins over Abort
      Abort = 1'b1;
      tick();
      check("idle_abort_busy", Busy, 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      Abort = 1'b0;
      check("start_vs_abort_busy", Busy, 1);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("start_vs_abort_stop", Busy, 0);

      // ---------------- full load, ROM[i] = i
      for (int i = 0; i < NW; i++) rom[i] = 10'(i);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      word = '0;
      nwe  = 0;
      for (int k = 1; k <= 790; k++) begin
         slot   = (k - 1) % 12;
         widx   = (k - 1) / 12;
         exp_we = (k <= 780) && (slot >= 2);
         check("full_we",   WE,   exp_we);
         check("full_busy", Busy, k <= 780);
         check("full_done", Done, k == 781);
         if (exp_we) begin
            bpos = 11 - slot;
            check("full_waddr", WAddr, widx);
            check("full_wbit",  WBit,  bpos);
            word = {word[W-2:0], Out};
            if (bpos == 0) check("full_word", word, widx);
         end else begin
            check("full_out_idle",  Out,  0);
            check("full_wbit_idle", WBit, 0);
         end
         if (WE) nwe++;
         tick();
      end
      check("full_we_count", nwe, NW * W);

      // ---------------- abort mid-load at WAddr=7, WBit=4
      Start = 1'b1;
      tick();
      Start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         if (WE && WAddr == 7 && WBit == 4) found = 1'b1;
         else tick();
      end
      check("abort_reach", found, 1);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("abort_we",    WE,   0);
      check("abort_busy",  Busy, 0);
      check("abort_out",   Out,  0);
      check("abort_wbit",  WBit, 0);
      check("abort_waddr", WAddr, 7);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("abort_no_done", Done, 0);
         check("abort_stay_we", WE,   0);
      end
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("restart_romaddr", RomAddr, 0);
      check("restart_busy",    Busy,    1);
      tick();
      tick();
      check("restart_we",    WE,    1);
      check("restart_waddr", WAddr, 0);
      check("restart_wbit",  WBit,  9);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("restart_stop", Busy, 0);

      // ---------------- async reset mid-shift at WAddr=30 (30 has bit4 set)
      Start = 1'b1;
      tick();
      Start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 500 && !found; n++) begin
         if (WE && WAddr == 30 && WBit == 4) found = 1'b1;
         else tick();
      end
      check("arst_reach",  found, 1);
      check("arst_pre_out", Out,  1);
      #2;
      Rst = 1'b1;
      #1;
      check("arst_we",   WE,   0);
      check("arst_busy", Busy, 0);
      check("arst_out",  Out,  0);
      check("arst_wbit", WBit, 0);
      tick();
      Rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("arst_no_done", Done, 0);
         check("arst_idle_we", WE,   0);
      end

      // ---------------- Start held high across a whole load
      Start = 1'b1;
      tick();
      done_k = 0;
      for (int k = 1; k <= 800 && done_k == 0; k++) begin
         if (Done) done_k = k;
         else tick();
      end
      check("held_done_cycle", done_k, 781);
      check("held_done_busy",  Busy,   0);
      tick();
      check("held_idle_busy", Busy, 0);
      check("held_idle_done", Done, 0);
      check("held_idle_we",   WE,   0);
      tick();
      check("held_refetch_busy",    Busy,    1);
      check("held_refetch_romaddr", RomAddr, 0);
      check("held_refetch_we",      WE,      0);
      Start = 1'b0;
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("held_stop_busy", Busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
